// File: rtl/text_link_scheduler.sv
// Purpose : moves 64-character frames from a pulse-driven source to a level/ack sink, MAX_FRAMES per transfer.
// Latency : src_frame_ready -> snk_data_valid in 2 cycles; snk_data_received -> next src_data_received in 2 cycles.
// Backpressure: one frame in flight; the source is only asked again after the sink acks; either side stalling for TIMEOUT_CYCLES raises timeout_err.
//
// Ports:
//   clk, reset (async, active-low)            clock / reset
//   start                                     begin a transfer (IDLE, DONE or ERROR only)
//   src_data, src_frame_ready                 frame and its one-cycle ready pulse from the source
//   src_data_received                         one-cycle request for the next source frame
//   snk_data, snk_data_valid                  latched frame to the sink, valid held until ack
//   snk_data_received                         one-cycle ack from the sink
//   frame_count, busy, done, timeout_err      transfer status (all registered)
module text_link_scheduler #(
    parameter int MAX_FRAMES     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [511:0] src_data,
    input  logic         src_frame_ready,
    output logic         src_data_received,
    output logic [511:0] snk_data,
    output logic         snk_data_valid,
    input  logic         snk_data_received,
    output logic [7:0]   frame_count,
    output logic         busy,
    output logic         done,
    output logic         timeout_err
);

    // Wide enough to hold TIMEOUT_CYCLES itself.
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW:0] TO_LIM  = TIMEOUT_CYCLES[TW:0];
    localparam logic [8:0]  MAX_LIM = MAX_FRAMES[8:0];

    typedef enum logic [3:0] {
        S_IDLE,
        S_REQUEST,
        S_WAIT_SRC,
        S_LATCH,
        S_SEND,
        S_WAIT_SNK,
        S_ACK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [TW-1:0]  r_tcnt;
    logic [TW:0]    w_tcnt_inc;
    logic           w_tcnt_expired;
    logic [8:0]     w_fc_plus1;
    logic [7:0]     w_fc_sat;

    logic [511:0]   r_snk_data;
    logic           r_snk_data_valid;
    logic           r_src_data_received;
    logic [7:0]     r_frame_count;
    logic           r_busy;
    logic           r_done;
    logic           r_timeout_err;

    assign w_tcnt_inc     = {1'b0, r_tcnt} + 1'b1;
    assign w_tcnt_expired = (w_tcnt_inc >= TO_LIM);
    assign w_fc_plus1     = {1'b0, r_frame_count} + 9'd1;
    assign w_fc_sat       = (&r_frame_count) ? r_frame_count : (r_frame_count + 8'd1);

    // Next state. The expected pulse is tested before the timeout so it wins a tie.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: if (start) w_next = S_REQUEST;
            S_REQUEST:               w_next = S_WAIT_SRC;
            S_WAIT_SRC: begin
                if (src_frame_ready)     w_next = S_LATCH;
                else if (w_tcnt_expired) w_next = S_ERROR;
            end
            S_LATCH:                 w_next = S_SEND;
            S_SEND:                  w_next = S_WAIT_SNK;
            S_WAIT_SNK: begin
                if (snk_data_received)   w_next = S_ACK;
                else if (w_tcnt_expired) w_next = S_ERROR;
            end
            S_ACK:                   w_next = (w_fc_plus1 == MAX_LIM) ? S_DONE : S_REQUEST;
            default:                 w_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the state being entered, so each one is
    // valid for exactly the cycles spent in that state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state             <= S_IDLE;
            r_tcnt              <= '0;
            r_snk_data          <= '0;
            r_snk_data_valid    <= 1'b0;
            r_src_data_received <= 1'b0;
            r_frame_count       <= 8'd0;
            r_busy              <= 1'b0;
            r_done              <= 1'b0;
            r_timeout_err       <= 1'b0;
        end else begin
            r_state             <= w_next;
            r_src_data_received <= (w_next == S_REQUEST);
            r_snk_data_valid    <= (w_next == S_SEND) || (w_next == S_WAIT_SNK);
            r_busy              <= !(w_next inside {S_IDLE, S_DONE, S_ERROR});
            r_done              <= (w_next == S_DONE);
            r_timeout_err       <= (w_next == S_ERROR);

            // Capture leaves LATCH together with valid rising, keeping
            // snk_data stable for the whole valid window.
            if (r_state == S_LATCH) r_snk_data <= src_data;

            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        r_frame_count <= 8'd0;
                        r_tcnt        <= '0;
                    end
                end
                S_WAIT_SRC: if (!src_frame_ready)   r_tcnt <= w_tcnt_inc[TW-1:0];
                S_LATCH:                            r_tcnt <= '0;
                S_WAIT_SNK: if (!snk_data_received) r_tcnt <= w_tcnt_inc[TW-1:0];
                S_ACK: begin
                    r_frame_count <= w_fc_sat;
                    r_tcnt        <= '0;
                end
                default: ;
            endcase
        end
    end

    assign snk_data          = r_snk_data;
    assign snk_data_valid    = r_snk_data_valid;
    assign src_data_received = r_src_data_received;
    assign frame_count       = r_frame_count;
    assign busy              = r_busy;
    assign done              = r_done;
    assign timeout_err       = r_timeout_err;

endmodule
